// File: rtl/dual_debounce_if.sv
// Signal bundle between the raw input source and the dual debouncer.
// There is no valid/ready handshake: a_raw/b_raw are free-running
// asynchronous levels, and every output is a registered level or a
// one-cycle pulse that is meaningful on every clock.
interface dual_debounce_if;
  logic a_raw;
  logic b_raw;
  logic a;
  logic b;
  logic a_rise;
  logic a_fall;
  logic b_rise;
  logic b_fall;
  logic settled;
  // FSM state per channel: 0 = IDLE, 1 = CHECK
  logic state_a_dbg;
  logic state_b_dbg;

  modport master (
    output a_raw, b_raw,
    input  a, b, a_rise, a_fall, b_rise, b_fall, settled,
    input  state_a_dbg, state_b_dbg
  );

  modport slave (
    input  a_raw, b_raw,
    output a, b, a_rise, a_fall, b_rise, b_fall, settled,
    output state_a_dbg, state_b_dbg
  );
endinterface

// File: rtl/dual_debounce.sv
// Two independent synchroniser + debounce channels (A = index 0, B = index 1).
// Each channel's output follows its synchronised input only after the input
// has disagreed with the output for STABLE_CNT consecutive cycles.
module dual_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CNT  = 4,
  parameter int CNT_W       = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  dual_debounce_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic [1:0]             raw;
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [SYNC_STAGES-1:0] sync_d [2];
  logic [1:0]             sync_last;
  logic [1:0]             sync_last_d;
  state_e                 state_q [2];
  state_e                 state_d [2];
  logic [CNT_W-1:0]       cnt_q [2];
  logic [CNT_W-1:0]       cnt_d [2];
  logic [1:0]             out_q, out_d;
  logic [1:0]             rise_q, rise_d;
  logic [1:0]             fall_q, fall_d;
  logic                   settled_q, settled_d;

  assign raw = {bus.b_raw, bus.a_raw};

  // Output of each synchroniser chain, now and after the coming edge
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      sync_last[c]   = sync_q[c][SYNC_STAGES-1];
      sync_last_d[c] = sync_q[c][SYNC_STAGES-2];
    end
  end

  // Synchroniser shift, per-channel debounce FSM, pulses and settle flag
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      sync_d[c]  = {sync_q[c][SYNC_STAGES-2:0], raw[c]};
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      out_d[c]   = out_q[c];
      rise_d[c]  = 1'b0;
      fall_d[c]  = 1'b0;
      case (state_q[c])
        IDLE: begin
          cnt_d[c] = '0;
          if (sync_last[c] != out_q[c]) begin
            if (STABLE_CNT == 1) begin
              out_d[c]  = sync_last[c];
              rise_d[c] = sync_last[c];
              fall_d[c] = ~sync_last[c];
            end else begin
              state_d[c] = CHECK;
              cnt_d[c]   = CNT_W'(1);
            end
          end
        end
        CHECK: begin
          if (sync_last[c] == out_q[c]) begin
            // Input bounced back before it was stable long enough
            state_d[c] = IDLE;
            cnt_d[c]   = '0;
          end else if (cnt_q[c] == CNT_LAST) begin
            out_d[c]   = sync_last[c];
            rise_d[c]  = sync_last[c];
            fall_d[c]  = ~sync_last[c];
            state_d[c] = IDLE;
            cnt_d[c]   = '0;
          end else begin
            cnt_d[c] = cnt_q[c] + CNT_W'(1);
          end
        end
        default: begin
          state_d[c] = IDLE;
          cnt_d[c]   = '0;
        end
      endcase
    end
    // Settle flag describes the state that will hold after this edge
    settled_d = (state_d[0] == IDLE) && (state_d[1] == IDLE) &&
                (sync_last_d[0] == out_d[0]) && (sync_last_d[1] == out_d[1]);
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        sync_q[c]  <= '0;
        state_q[c] <= IDLE;
        cnt_q[c]   <= '0;
      end
      out_q     <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      settled_q <= 1'b1;
    end else begin
      for (int c = 0; c < 2; c++) begin
        sync_q[c]  <= sync_d[c];
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
      out_q     <= out_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      settled_q <= settled_d;
    end
  end

  assign bus.a           = out_q[0];
  assign bus.b           = out_q[1];
  assign bus.a_rise      = rise_q[0];
  assign bus.a_fall      = fall_q[0];
  assign bus.b_rise      = rise_q[1];
  assign bus.b_fall      = fall_q[1];
  assign bus.settled     = settled_q;
  assign bus.state_a_dbg = state_q[0];
  assign bus.state_b_dbg = state_q[1];

endmodule

// File: tb/tb_dual_debounce.sv
// Directed bench for dual_debounce: default build (2 sync stages, 4 stable
// cycles) plus a STABLE_CNT=1 build. Expected values are hand-derived edge
// counts relative to the capture edge N.
module tb_dual_debounce;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  dual_debounce_if bus0 ();
  dual_debounce_if bus1 ();

  dual_debounce #(.SYNC_STAGES(2), .STABLE_CNT(4), .CNT_W(8)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  dual_debounce #(.SYNC_STAGES(2), .STABLE_CNT(1), .CNT_W(8)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rises;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus0.a_raw = 1'b1;
    bus0.b_raw = 1'b1;
    bus1.a_raw = 1'b0;
    bus1.b_raw = 1'b0;

    // 1. Reset with both raw inputs high
    #20;
    check("rst_a", bus0.a, 0);
    check("rst_b", bus0.b, 0);
    check("rst_pulses", {bus0.a_rise, bus0.a_fall, bus0.b_rise, bus0.b_fall}, 0);
    check("rst_settled", bus0.settled, 1);
    check("rst_state", {bus0.state_a_dbg, bus0.state_b_dbg}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      check("rel_a", bus0.a, (i >= 5));
      check("rel_b", bus0.b, (i >= 5));
      check("rel_a_rise", bus0.a_rise, (i == 5));
      check("rel_b_rise", bus0.b_rise, (i == 5));
      check("rel_settled", bus0.settled, (i == 0 || i >= 5));
    end

    // 2a. Clean fall on A, B untouched
    bus0.a_raw = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      check("fall_a", bus0.a, (i < 5));
      check("fall_a_fall", bus0.a_fall, (i == 5));
      check("fall_a_rise", bus0.a_rise, 0);
      check("fall_b", bus0.b, 1);
    end

    // 2b. Clean rise on A
    bus0.a_raw = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      check("step_a", bus0.a, (i >= 5));
      check("step_a_rise", bus0.a_rise, (i == 5));
      check("step_a_fall", bus0.a_fall, 0);
      check("step_b", bus0.b, 1);
      check("step_b_rise", bus0.b_rise, 0);
    end

    // 3. Glitch of 3 cycles on A starting from a = 0
    bus0.a_raw = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("glitch_pre_a", bus0.a, 0);
    for (int i = 0; i < 9; i++) begin
      bus0.a_raw = (i < 3);
      step();
      check("glitch_a", bus0.a, 0);
      check("glitch_rise", bus0.a_rise, 0);
      check("glitch_fall", bus0.a_fall, 0);
    end
    check("glitch_state", bus0.state_a_dbg, 0);
    check("glitch_settled", bus0.settled, 1);

    // 4. Bounce 1,0,1,0 then hold 1: hold starts at N+4, a rises at N+9
    rises = 0;
    for (int i = 0; i < 11; i++) begin
      bus0.a_raw = (i < 4) ? ((i % 2) == 0) : 1'b1;
      step();
      if (bus0.a_rise) rises++;
      check("bounce_a", bus0.a, (i >= 9));
      check("bounce_rise", bus0.a_rise, (i == 9));
    end
    check("bounce_rise_count", rises, 1);

    // 5a. Simultaneous rise on both channels
    bus0.a_raw = 1'b0;
    bus0.b_raw = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("sim_pre_ab", {bus0.a, bus0.b}, 0);
    bus0.a_raw = 1'b1;
    bus0.b_raw = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      check("sim_a", bus0.a, (i >= 5));
      check("sim_b", bus0.b, (i >= 5));
      check("sim_b_rise", bus0.b_rise, (i == 5));
    end

    // 5b. Reset two cycles into a falling CHECK
    bus0.a_raw = 1'b0;
    bus0.b_raw = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("mid_state_chk", {bus0.state_a_dbg, bus0.state_b_dbg}, 2'b11);
    check("mid_a_held", bus0.a, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ab", {bus0.a, bus0.b}, 0);
    check("mid_rst_state", {bus0.state_a_dbg, bus0.state_b_dbg}, 0);
    check("mid_rst_pulses", {bus0.a_rise, bus0.a_fall, bus0.b_rise, bus0.b_fall}, 0);
    check("mid_rst_settled", bus0.settled, 1);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("post_rst_ab", {bus0.a, bus0.b}, 0);
      check("post_rst_pulses", {bus0.a_rise, bus0.a_fall, bus0.b_rise, bus0.b_fall}, 0);
    end
    check("post_rst_settled", bus0.settled, 1);

    // 6. STABLE_CNT=1: single-cycle pulse passes through at N+2
    bus1.a_raw = 1'b1;
    step();
    check("s1_a0", bus1.a, 0);
    bus1.a_raw = 1'b0;
    for (int i = 1; i < 6; i++) begin
      step();
      check("s1_a", bus1.a, (i == 2));
      check("s1_rise", bus1.a_rise, (i == 2));
      check("s1_fall", bus1.a_fall, (i == 3));
      check("s1_b", bus1.b, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
